// File: rtl/reg_wb_pkg.sv
// Shared constants, request record and helpers for the register-file writeback path.
package reg_wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int WB_MAX_REQ = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  // Width of a requester index; kept at least 1 so single-entry vectors stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bundle: N requesters on one side, the register-file write port on the other.
interface reg_wb_arbiter_if
  import reg_wb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
);

  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ*AW-1:0] i_req_addr;
  logic [N_REQ*DW-1:0] i_req_data;
  logic [N_REQ-1:0]    o_req_ready;
  logic                o_we;
  logic [AW-1:0]       o_waddr;
  logic [DW-1:0]       o_wdata;
  logic                o_busy;

  modport master (
    output i_req_valid, i_req_addr, i_req_data,
    input  o_req_ready, o_we, o_waddr, o_wdata, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data,
    output o_req_ready, o_we, o_waddr, o_wdata, o_busy
  );

endinterface

// File: rtl/reg_wb_arbiter_rr.sv
// Generic rotate-priority picker: one-hot grant to the first set req starting at ptr_i.
module rr_arbiter
  import reg_wb_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o
);

  logic [PW:0] idx_s;
  logic        found_s;
  logic        hit_s;

  // Scan ptr_i, ptr_i+1, ... modulo N and keep the first valid requester.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s = {1'b0, ptr_i} + (PW+1)'(i);
      idx_s = (idx_s >= (PW+1)'(N)) ? (idx_s - (PW+1)'(N)) : idx_s;
      hit_s = enable_i & ~found_s & req_i[idx_s[PW-1:0]];
      grant_o[idx_s[PW-1:0]] = grant_o[idx_s[PW-1:0]] | hit_s;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter with a one-entry output stage that stalls under i_hold.
// Optional macro WB_BYPASS_EN adds two combinational read-forwarding ports.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_hold,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic          o_fwd_hit1,
  output logic          o_fwd_hit2,
  output logic [DW-1:0] o_fwd_data1,
  output logic [DW-1:0] o_fwd_data2,
`endif
  reg_wb_arbiter_if.slave bus
);

  localparam int PW = ptr_width(N_REQ);

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q,  out_addr_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [PW-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N_REQ-1:0] grant_s;
  logic             can_load_s;
  logic             accept_s;
  logic [AW-1:0]    win_addr_s;
  logic [DW-1:0]    win_data_s;
  logic [PW-1:0]    win_next_s;

  // An empty stage, or one that commits this cycle, can take a new write.
  assign can_load_s = ~out_valid_q | ~i_hold;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i    (bus.i_req_valid),
    .ptr_i    (rr_ptr_q),
    .enable_i (can_load_s),
    .grant_o  (grant_s)
  );

  // One-hot AND-OR mux of the winning requester's fields and its successor index.
  always_comb begin
    win_addr_s = '0;
    win_data_s = '0;
    win_next_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      win_addr_s = win_addr_s | ({AW{grant_s[k]}} & bus.i_req_addr[k*AW +: AW]);
      win_data_s = win_data_s | ({DW{grant_s[k]}} & bus.i_req_data[k*DW +: DW]);
      win_next_s = win_next_s | ({PW{grant_s[k]}} & PW'((k + 1) % N_REQ));
    end
    accept_s = |grant_s;
  end

  // Next state of the output stage; writes to x0 are accepted but never buffered.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (can_load_s) begin
      if (accept_s) begin
        rr_ptr_d = win_next_s;
        if (win_addr_s != AW'(REG_ZERO)) begin
          out_valid_d = 1'b1;
          out_addr_d  = win_addr_s;
          out_data_d  = win_data_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage and round-robin pointer registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.o_req_ready = grant_s;
  assign bus.o_we        = out_valid_q & ~i_hold;
  assign bus.o_waddr     = out_addr_q;
  assign bus.o_wdata     = out_data_q;
  assign bus.o_busy      = out_valid_q;

`ifdef WB_BYPASS_EN
  // Forward straight from the stage so readers see a write still parked under hold.
  assign o_fwd_hit1  = out_valid_q & (i_raddr1 == out_addr_q) & (i_raddr1 != AW'(REG_ZERO));
  assign o_fwd_hit2  = out_valid_q & (i_raddr2 == out_addr_q) & (i_raddr2 != AW'(REG_ZERO));
  assign o_fwd_data1 = out_data_q;
  assign o_fwd_data2 = out_data_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter (N_REQ=3): directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

  localparam int N = 3;

  logic clk;
  logic rst;
  logic hold;
  int   n_checks;
  int   n_errors;

  reg_wb_arbiter_if #(.N_REQ(N), .AW(5), .DW(32)) bus ();

`ifdef WB_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  reg_wb_arbiter #(.N_REQ(N), .AW(5), .DW(32)) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_hold      (hold),
`ifdef WB_BYPASS_EN
    .i_raddr1    (raddr1),
    .i_raddr2    (raddr2),
    .o_fwd_hit1  (fwd_hit1),
    .o_fwd_hit2  (fwd_hit2),
    .o_fwd_data1 (fwd_data1),
    .o_fwd_data2 (fwd_data2),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: priority pointer and the one buffered write.
  int      m_ptr;
  wb_req_t m_buf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_buf = '0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model, wait for posedge.
  task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                      input logic h, output logic [2:0] obs_rdy, output logic [2:0] exp_rdy);
    int   win;
    logic can;
    logic [4:0] wa;
    @(negedge clk);
    bus.i_req_valid = v;
    bus.i_req_addr  = a;
    bus.i_req_data  = d;
    hold            = h;
    #1;
    can = !m_buf.valid || !h;
    win = -1;
    if (can) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && ((v >> ((m_ptr + i) % N)) & 3'b001) != 3'b000) win = (m_ptr + i) % N;
      end
    end
    exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
    obs_rdy = bus.o_req_ready;
    check("ready", 32'(bus.o_req_ready), 32'(exp_rdy));
    check("we", 32'(bus.o_we), 32'(m_buf.valid & ~h));
    check("busy", 32'(bus.o_busy), 32'(m_buf.valid));
    if (m_buf.valid && !h) begin
      check("waddr", 32'(bus.o_waddr), 32'(m_buf.addr));
      check("wdata", bus.o_wdata, m_buf.data);
    end
    if (can) begin
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        wa = 5'(a >> (5 * win));
        m_buf.valid = (wa != 5'd0);
        if (wa != 5'd0) begin
          m_buf.addr = wa;
          m_buf.data = 32'(d >> (32 * win));
        end
      end else begin
        m_buf.valid = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  logic [2:0]  obs, exp;
  logic        pv [N];
  logic [4:0]  pa [N];
  logic [31:0] pd [N];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    hold = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_addr  = '0;
    bus.i_req_data  = '0;
`ifdef WB_BYPASS_EN
    raddr1 = 5'd0;
    raddr2 = 5'd0;
`endif
    model_reset();

    // Reset state.
    #1;
    check("rst_we", 32'(bus.o_we), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_waddr", 32'(bus.o_waddr), 32'd0);
    check("rst_wdata", bus.o_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request: ready at t, write at t+1.
    step(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, obs, exp);
    check("single_ready", 32'(obs), 32'd1);
    #1;
    check("single_we", 32'(bus.o_we), 32'd1);
    check("single_waddr", 32'(bus.o_waddr), 32'd5);
    check("single_wdata", bus.o_wdata, 32'hDEADBEEF);

    // Reset mid-write discards the buffered entry.
    step(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, obs, exp);
    #1;
    bus.i_req_valid = 3'b000;
    rst = 1'b1;
    #1;
    check("rstmid_we", 32'(bus.o_we), 32'd0);
    check("rstmid_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_hold_we", 32'(bus.o_we), 32'd0);
    rst = 1'b0;
    model_reset();

    // Contention: all valid, grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      step(3'b111, {5'd3, 5'd2, 5'd1}, {$urandom, $urandom, $urandom}, 1'b0, obs, exp);
      check("cont_grant", 32'(obs), 32'(3'b001 << (i % 3)));
    end
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);

    // Hold backpressure: buffered write frozen, released exactly once.
    step(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h11, 32'd0}, 1'b0, obs, exp);
    check("hold_acc", 32'(obs), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(3'b111, {5'd1, 5'd2, 5'd3}, {32'd1, 32'd2, 32'd3}, 1'b1, obs, exp);
      check("hold_rdy", 32'(obs), 32'd0);
      #1;
      check("hold_we", 32'(bus.o_we), 32'd0);
      check("hold_busy", 32'(bus.o_busy), 32'd1);
      check("hold_waddr", 32'(bus.o_waddr), 32'd7);
      check("hold_wdata", bus.o_wdata, 32'h11);
    end
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);
    #1;
    check("hold_once", 32'(bus.o_busy), 32'd0);

    // x0 drop: accepted, no write, pointer moves to 1.
    step(3'b001, 15'd0, {64'd0, 32'hFFFFFFFF}, 1'b0, obs, exp);
    check("x0_ready", 32'(obs), 32'd1);
    #1;
    check("x0_we", 32'(bus.o_we), 32'd0);
    step(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1}, 1'b0, obs, exp);
    check("x0_ptr", 32'(obs), 32'd2);
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);

`ifdef WB_BYPASS_EN
    // Forwarding from a write parked under hold.
    step(3'b001, {10'd0, 5'd9}, {64'd0, 32'hCAFE0009}, 1'b0, obs, exp);
    step(3'b000, 15'd0, 96'd0, 1'b1, obs, exp);
    raddr1 = 5'd9;
    raddr2 = 5'd0;
    #1;
    check("fwd_hit1", 32'(fwd_hit1), 32'd1);
    check("fwd_data1", fwd_data1, 32'hCAFE0009);
    check("fwd_hit2", 32'(fwd_hit2), 32'd0);
    raddr1 = 5'd10;
    #1;
    check("fwd_miss1", 32'(fwd_hit1), 32'd0);
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);
`endif

    // Random traffic: requesters hold their request stable until accepted.
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b0;
      pa[k] = 5'd0;
      pd[k] = 32'd0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k] && $urandom_range(0, 1) == 1) begin
          pv[k] = 1'b1;
          pa[k] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[k] = $urandom;
        end
      end
      step({pv[2], pv[1], pv[0]}, {pa[2], pa[1], pa[0]}, {pd[2], pd[1], pd[0]},
           ($urandom_range(0, 3) == 0), obs, exp);
      for (int k = 0; k < N; k++) begin
        if (((exp >> k) & 3'b001) != 3'b000) pv[k] = 1'b0;
      end
    end
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);
    step(3'b000, 15'd0, 96'd0, 1'b0, obs, exp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
